// File: rtl/uop_pkg.sv
// Shared microop definitions used by fetch, queue and decode.
// The microcode ROM generator and the decode stage use the same constants.
package uop_pkg;

   localparam int UOP_WIDTH = 24;
   localparam logic [UOP_WIDTH-1:0] UOP_NOP = 24'h000000;

   // Width of one fetch bundle holding issue_width microops.
   function automatic int bundle_width(input int issue_width);
      return issue_width * UOP_WIDTH;
   endfunction

endpackage

// File: rtl/uop_compact.sv
// Fetch bundle compactor: finds the non-NOP slots of a bundle and gives each one
// a dense write offset in program order.
module uop_compact
   import uop_pkg::*;
#(
   parameter int ISSUE_WIDTH = 4
) (
   input  logic [bundle_width(ISSUE_WIDTH)-1:0]          microops,
   output logic [ISSUE_WIDTH-1:0][$clog2(ISSUE_WIDTH+1)-1:0] offset,
   output logic [ISSUE_WIDTH-1:0]                        we,
   output logic [$clog2(ISSUE_WIDTH+1)-1:0]              n_wr
);

   localparam int CW = $clog2(ISSUE_WIDTH + 1);

   logic [CW-1:0] acc_s;

   // Prefix count of occupied slots: each slot lands after all older occupied slots.
   always_comb begin
      acc_s  = {CW{1'b0}};
      offset = '0;
      we     = '0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         offset[i] = acc_s;
         if (microops[UOP_WIDTH*i +: UOP_WIDTH] != UOP_NOP) begin
            we[i] = 1'b1;
            acc_s = acc_s + CW'(1);
         end else begin
            we[i] = 1'b0;
         end
      end
      n_wr = acc_s;
   end

endmodule

// File: rtl/uop_queue.sv
// Microop queue: accepts compacted fetch bundles into a circular FIFO and hands
// microops one per cycle to rename/dispatch over a valid/ready handshake.
module uop_queue
   import uop_pkg::*;
#(
   parameter int ISSUE_WIDTH = 4,
   parameter int DEPTH       = 16
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   flush,
   input  logic [bundle_width(ISSUE_WIDTH)-1:0]   microops,
   output logic                                   microops_ready,
   output logic [UOP_WIDTH-1:0]                   uop_out,
   output logic                                   uop_valid,
   input  logic                                   uop_ready,
   output logic [$clog2(DEPTH):0]                 count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(ISSUE_WIDTH + 1);
   localparam int NW = $clog2(DEPTH) + 1;

   logic [UOP_WIDTH-1:0]           mem_r [DEPTH];
   logic [PW-1:0]                  head_r;
   logic [PW-1:0]                  tail_r;
   logic [NW-1:0]                  count_r;

   logic [ISSUE_WIDTH-1:0][CW-1:0] offset_s;
   logic [ISSUE_WIDTH-1:0]         we_s;
   logic [CW-1:0]                  n_wr_s;
   logic [ISSUE_WIDTH-1:0][PW-1:0] wr_addr_s;
   logic                           push_s;
   logic                           pop_s;

   uop_compact #(
      .ISSUE_WIDTH (ISSUE_WIDTH)
   ) u_compact (
      .microops (microops),
      .offset   (offset_s),
      .we       (we_s),
      .n_wr     (n_wr_s)
   );

   // Accept only when a worst-case bundle fits, judged on the pre-pop count.
   always_comb begin
      push_s = !rst && !flush && (count_r <= NW'(DEPTH - ISSUE_WIDTH));
      pop_s  = (count_r != NW'(0)) && uop_ready && !flush;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         wr_addr_s[i] = tail_r + PW'(offset_s[i]);
      end
   end

   assign microops_ready = push_s;
   assign uop_valid      = !rst && (count_r != NW'(0));
   assign uop_out        = mem_r[head_r];
   assign count          = count_r;

   // Storage write; contents are don't-care after reset or flush.
   always_ff @(posedge clk) begin
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         if (push_s && we_s[i]) begin
            mem_r[wr_addr_s[i]] <= microops[UOP_WIDTH*i +: UOP_WIDTH];
         end
      end
   end

   // Pointer and occupancy update; reset beats flush beats handshakes.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_r  <= {PW{1'b0}};
         tail_r  <= {PW{1'b0}};
         count_r <= {NW{1'b0}};
      end else if (flush) begin
         head_r  <= {PW{1'b0}};
         tail_r  <= {PW{1'b0}};
         count_r <= {NW{1'b0}};
      end else begin
         if (push_s) begin
            tail_r <= tail_r + PW'(n_wr_s);
         end
         if (pop_s) begin
            head_r <= head_r + PW'(1);
         end
         count_r <= count_r + (push_s ? NW'(n_wr_s) : NW'(0)) - (pop_s ? NW'(1) : NW'(0));
      end
   end

endmodule

// File: tb/tb_uop_queue.sv
// Directed and randomized bench for uop_queue against a queue-based reference model.
module tb_uop_queue;
   import uop_pkg::*;

   localparam int IW = 4;
   localparam int D  = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [95:0] microops;
   logic        microops_ready;
   logic [23:0] uop_out;
   logic        uop_valid;
   logic        uop_ready;
   logic [4:0]  count;

   int n_cmp = 0;
   int n_bad = 0;
   logic [23:0] mq[$];
   logic [23:0] plog[$];

   uop_queue #(.ISSUE_WIDTH(IW), .DEPTH(D)) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .microops       (microops),
      .microops_ready (microops_ready),
      .uop_out        (uop_out),
      .uop_valid      (uop_valid),
      .uop_ready      (uop_ready),
      .count          (count)
   );

   always #5 clk = ~clk;

   function automatic logic [95:0] mk(input logic [23:0] s0, s1, s2, s3);
      return {s3, s2, s1, s0};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, compare at the falling edge, advance the model.
   task automatic cycle(input logic [95:0] b, input logic ur, input logic fl, input logic rs);
      bit exp_rdy;
      logic [23:0] slot;
      microops  = b;
      uop_ready = ur;
      flush     = fl;
      rst       = rs;
      @(negedge clk);
      exp_rdy = !rs && !fl && ((D - mq.size()) >= IW);
      check("microops_ready", 32'(microops_ready), 32'(exp_rdy));
      check("uop_valid", 32'(uop_valid), 32'(!rs && mq.size() != 0));
      check("count", 32'(count), 32'(mq.size()));
      if (!rs && mq.size() != 0) check("uop_out", 32'(uop_out), 32'(mq[0]));
      if (rs || fl) begin
         mq.delete();
      end else begin
         if (mq.size() != 0 && ur) plog.push_back(mq.pop_front());
         if (exp_rdy) begin
            for (int s = 0; s < IW; s++) begin
               slot = b[24*s +: 24];
               if (slot != UOP_NOP) mq.push_back(slot);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [23:0] nxt;
      logic [23:0] tmp;
      logic [95:0] b;
      logic        ur;
      int          sent;

      rst = 1'b1; flush = 1'b0; uop_ready = 1'b0;
      microops = mk(24'h1, 24'h2, 24'h3, 24'h4);
      @(posedge clk);
      #1;

      // Reset held two cycles with a full bundle present, then release.
      cycle(mk(24'h1, 24'h2, 24'h3, 24'h4), 1'b0, 1'b0, 1'b1);
      cycle(mk(24'h1, 24'h2, 24'h3, 24'h4), 1'b0, 1'b0, 1'b1);
      cycle(96'h0, 1'b0, 1'b0, 1'b0);

      // Compaction of a sparse bundle.
      plog.delete();
      cycle(mk(24'h0, 24'h0A0001, 24'h0, 24'h0B0002), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(96'h0, 1'b1, 1'b0, 1'b0);
      check("compact_n", 32'(plog.size()), 32'd2);
      if (plog.size() == 2) begin
         check("compact_0", 32'(plog[0]), 32'h0A0001);
         check("compact_1", 32'(plog[1]), 32'h0B0002);
      end

      // Fill to full under backpressure, pop down to the accept threshold.
      plog.delete();
      for (int k = 0; k < 4; k++) begin
         tmp = 24'h100 + 24'(4 * k);
         cycle(mk(tmp + 24'd1, tmp + 24'd2, tmp + 24'd3, tmp + 24'd4), 1'b0, 1'b0, 1'b0);
      end
      for (int k = 0; k < 4; k++) cycle(mk(24'h900, 24'h901, 24'h902, 24'h903), 1'b1, 1'b0, 1'b0);
      // Push and pop together at count 12.
      cycle(mk(24'h201, 24'h202, 24'h203, 24'h204), 1'b1, 1'b0, 1'b0);
      cycle(96'h0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 16; k++) cycle(96'h0, 1'b1, 1'b0, 1'b0);
      check("full_n", 32'(plog.size()), 32'd20);
      for (int k = 0; k < 20 && k < plog.size(); k++) begin
         check("full_order", 32'(plog[k]), (k < 16) ? 32'(24'h101 + 24'(k)) : 32'(24'h201 + 24'(k - 16)));
      end

      // Flush at count 7 with a bundle present; the next bundle goes in normally.
      plog.delete();
      cycle(mk(24'h301, 24'h302, 24'h303, 24'h304), 1'b0, 1'b0, 1'b0);
      cycle(mk(24'h305, 24'h0, 24'h306, 24'h307), 1'b0, 1'b0, 1'b0);
      cycle(mk(24'h401, 24'h402, 24'h403, 24'h404), 1'b1, 1'b1, 1'b0);
      cycle(mk(24'h501, 24'h502, 24'h503, 24'h504), 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) cycle(96'h0, 1'b1, 1'b0, 1'b0);
      check("flush_n", 32'(plog.size()), 32'd4);
      for (int k = 0; k < 4 && k < plog.size(); k++) begin
         check("flush_order", 32'(plog[k]), 32'(24'h501 + 24'(k)));
      end

      // Random stream of 40 bundles across many pointer wraps.
      plog.delete();
      nxt  = 24'd1;
      sent = 0;
      for (int cyc = 0; cyc < 800 && sent < 40; cyc++) begin
         tmp = nxt;
         b   = 96'h0;
         for (int s = 0; s < IW; s++) begin
            if ($urandom_range(0, 3) != 0) begin
               b[24*s +: 24] = tmp;
               tmp = tmp + 24'd1;
            end
         end
         ur = 1'($urandom_range(0, 1));
         if ((D - mq.size()) >= IW) begin
            nxt  = tmp;
            sent = sent + 1;
         end
         cycle(b, ur, 1'b0, 1'b0);
      end
      for (int k = 0; k < 64 && mq.size() != 0; k++) cycle(96'h0, 1'b1, 1'b0, 1'b0);
      check("wrap_sent", 32'(sent), 32'd40);
      check("wrap_drained", 32'(mq.size()), 32'd0);
      check("wrap_n", 32'(plog.size()), 32'(nxt - 24'd1));
      for (int k = 0; k < plog.size(); k++) begin
         check("wrap_order", 32'(plog[k]), 32'(k + 1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
